ign_scheduler_n: RTL

IGN_SCHEDULER_N -- requirements
Module: ign_scheduler_n

---
 rtl/ign_scheduler_n_pkg.sv | 15 +
 rtl/ign_phase_tracker.sv | 70 +++++++
 rtl/ign_scheduler_n.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ign_scheduler_n_pkg.sv
// Shared ignition package: default parameters and channel FSM encoding
// used by the scheduler and its phase tracker.
package ign_scheduler_n_pkg;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_ANGLE_W        = 16;
    localparam int DEF_PERIOD_W       = 32;
    localparam int DEF_MAX_DWELL_CLKS = 400000;
    localparam int DEF_MIN_OFF_CLKS   = 2000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHARGE  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

endpackage

// File: rtl/ign_phase_tracker.sv
// Interpolates engine angle between tooth strobes; the angle never runs past
// the predicted position of the next tooth.
module ign_phase_tracker
    import ign_scheduler_n_pkg::*;
#(
    parameter int ANGLE_W  = DEF_ANGLE_W,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic                trigger,
    input  logic [ANGLE_W-1:0]  eng_phase,
    input  logic [ANGLE_W-1:0]  next_tooth_width,
    input  logic [PERIOD_W-1:0] quanta_period,
    input  logic [ANGLE_W-1:0]  quanta_per_revolution,
    output logic [ANGLE_W-1:0]  cur_angle,
    output logic [ANGLE_W-1:0]  angle_next
);

    logic [PERIOD_W-1:0] quanta_cnt_reg, quanta_cnt_next;
    logic [PERIOD_W-1:0] period_last;
    logic [ANGLE_W-1:0]  angle_reg, stop_reg, stop_next, step_angle;
    logic [ANGLE_W:0]    stop_sum, rev_ext;
    logic                terminal;

    always_comb begin
        rev_ext     = {1'b0, quanta_per_revolution};
        // A zero period behaves like one: step every clock.
        period_last = (quanta_period == '0) ? '0 : quanta_period - PERIOD_W'(1);
        terminal    = (quanta_cnt_reg >= period_last);
        step_angle  = (angle_reg == quanta_per_revolution - ANGLE_W'(1)) ? '0
                                                                         : angle_reg + ANGLE_W'(1);
        stop_sum    = {1'b0, eng_phase} + {1'b0, next_tooth_width};
        stop_next   = (stop_sum >= rev_ext) ? ANGLE_W'(stop_sum - rev_ext) : ANGLE_W'(stop_sum);

        angle_next      = angle_reg;
        quanta_cnt_next = quanta_cnt_reg;
        if (trigger) begin
            angle_next      = eng_phase;
            quanta_cnt_next = '0;
        end else if (sync) begin
            if (terminal) begin
                quanta_cnt_next = '0;
                if (step_angle != stop_reg) begin
                    angle_next = step_angle;
                end
            end else begin
                quanta_cnt_next = quanta_cnt_reg + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            angle_reg      <= '0;
            quanta_cnt_reg <= '0;
            stop_reg       <= '0;
        end else begin
            angle_reg      <= angle_next;
            quanta_cnt_reg <= quanta_cnt_next;
            if (trigger) begin
                stop_reg <= stop_next;
            end
        end
    end

    assign cur_angle = angle_reg;

endmodule

// File: rtl/ign_scheduler_n.sv
// N-channel ignition scheduler: per-channel charge/fire angles evaluated
// against every move of the shared interpolated engine angle.
module ign_scheduler_n
    import ign_scheduler_n_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int ANGLE_W        = DEF_ANGLE_W,
    parameter int PERIOD_W       = DEF_PERIOD_W,
    parameter int MAX_DWELL_CLKS = DEF_MAX_DWELL_CLKS,
    parameter int MIN_OFF_CLKS   = DEF_MIN_OFF_CLKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          en,
    input  logic                     sync,
    input  logic                     trigger,
    input  logic [ANGLE_W-1:0]       eng_phase,
    input  logic [ANGLE_W-1:0]       next_tooth_width,
    input  logic [PERIOD_W-1:0]      quanta_period,
    input  logic [ANGLE_W-1:0]       quanta_per_revolution,
    input  logic [ANGLE_W-1:0]       ign_timing,
    input  logic [ANGLE_W-1:0]       dwell_angle,
    input  logic [N_CH*ANGLE_W-1:0]  cyl_phase,
    output logic [N_CH-1:0]          spk_out,
    output logic [N_CH-1:0]          overdwell,
    output logic [ANGLE_W-1:0]       cur_angle
);

    localparam int DW = $clog2(MAX_DWELL_CLKS + 2);
    localparam int OW = $clog2(MIN_OFF_CLKS + 2);
    localparam logic [DW-1:0]      DWELL_LAST = DW'(MAX_DWELL_CLKS - 1);
    localparam logic [OW-1:0]      OFF_LAST   = OW'(MIN_OFF_CLKS - 1);
    localparam logic [ANGLE_W:0]   ONE_EXT    = 1;

    // (a - b) mod m for a, b already reduced below m.
    function automatic logic [ANGLE_W:0] mod_diff(input logic [ANGLE_W:0] a,
                                                  input logic [ANGLE_W:0] b,
                                                  input logic [ANGLE_W:0] m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

    logic [ANGLE_W-1:0] angle_next;
    logic [ANGLE_W:0]   rev_ext, old_ext, span, dwell_lim;

    ign_phase_tracker #(
        .ANGLE_W  (ANGLE_W),
        .PERIOD_W (PERIOD_W)
    ) u_tracker (
        .clk                   (clk),
        .rst                   (rst),
        .sync                  (sync),
        .trigger               (trigger),
        .eng_phase             (eng_phase),
        .next_tooth_width      (next_tooth_width),
        .quanta_period         (quanta_period),
        .quanta_per_revolution (quanta_per_revolution),
        .cur_angle             (cur_angle),
        .angle_next            (angle_next)
    );

    // Angle swept this clock; targets in (old, new] modulo rev are crossed.
    always_comb begin
        rev_ext   = {1'b0, quanta_per_revolution};
        old_ext   = {1'b0, cur_angle};
        span      = mod_diff({1'b0, angle_next}, old_ext, rev_ext);
        dwell_lim = ({1'b0, dwell_angle} >= rev_ext) ? rev_ext - ONE_EXT : {1'b0, dwell_angle};
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [ANGLE_W:0]   fire_sum, fire_mod, charge_mod, fire_dt, charge_dt;
            logic [ANGLE_W-1:0] fire_reg, charge_reg;
            logic               fire_hit, charge_hit;
            logic [1:0]         state_reg, state_next;
            logic [DW-1:0]      dwell_reg, dwell_next;
            logic [OW-1:0]      off_reg, off_next;
            logic               od_reg, od_next;

            always_comb begin
                fire_sum   = {1'b0, ign_timing} + {1'b0, cyl_phase[gi*ANGLE_W +: ANGLE_W]};
                fire_mod   = (fire_sum >= rev_ext) ? fire_sum - rev_ext : fire_sum;
                charge_mod = mod_diff(fire_mod, dwell_lim, rev_ext);
                fire_dt    = mod_diff({1'b0, fire_reg}, old_ext, rev_ext);
                charge_dt  = mod_diff({1'b0, charge_reg}, old_ext, rev_ext);
                fire_hit   = (fire_dt != '0) && (fire_dt <= span);
                charge_hit = (charge_dt != '0) && (charge_dt <= span);
            end

            always_comb begin
                state_next = state_reg;
                dwell_next = dwell_reg;
                off_next   = off_reg;
                od_next    = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        // A fire crossing in the same sweep suppresses the charge.
                        if (charge_hit && !fire_hit && en[gi] && sync) begin
                            state_next = ST_CHARGE;
                            dwell_next = '0;
                        end
                    end
                    ST_CHARGE: begin
                        if (fire_hit || !en[gi] || !sync) begin
                            state_next = ST_HOLDOFF;
                            off_next   = '0;
                        end else if (dwell_reg == DWELL_LAST) begin
                            state_next = ST_HOLDOFF;
                            off_next   = '0;
                            od_next    = 1'b1;
                        end else begin
                            dwell_next = dwell_reg + DW'(1);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (off_reg == OFF_LAST) begin
                            state_next = ST_IDLE;
                        end else begin
                            off_next = off_reg + OW'(1);
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fire_reg   <= '0;
                    charge_reg <= '0;
                    state_reg  <= ST_IDLE;
                    dwell_reg  <= '0;
                    off_reg    <= '0;
                    od_reg     <= 1'b0;
                end else begin
                    fire_reg   <= ANGLE_W'(fire_mod);
                    charge_reg <= ANGLE_W'(charge_mod);
                    state_reg  <= state_next;
                    dwell_reg  <= dwell_next;
                    off_reg    <= off_next;
                    od_reg     <= od_next;
                end
            end

            assign spk_out[gi]   = (state_reg == ST_CHARGE);
            assign overdwell[gi] = od_reg;
        end
    endgenerate

endmodule
